// File: rtl/vga_stream_gen.sv
// VGA source-side timing and pixel generator.
// Horizontal/vertical counters issue pixel requests to an external source and
// delay the sync/blank state so that each pixel's colour leaves in the same
// cycle as its own blanking and sync levels. Built-in test patterns can
// replace the external source on a per-frame basis.
//
// Request contract: pix_req is high for exactly one cycle per active pixel,
// with (pix_x, pix_y) naming that pixel. There is no back-pressure. The source
// must present that pixel's colour on pix_rgb exactly PIX_LAT cycles later.
// pix_rgb is ignored in every other cycle.
module vga_stream_gen #(
  parameter int WIDTH   = 800,
  parameter int HEIGHT  = 480,
  parameter int H_FP    = 40,
  parameter int H_SYNC  = 128,
  parameter int H_BP    = 88,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int PIX_LAT = 2
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [23:0] pix_rgb,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_SYNC_N,
  output logic        oVGA_BLANK_N,
  output logic        frame_start
);

  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = WIDTH / 8;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(WIDTH);
  localparam logic [9:0]  V_ACT  = 10'(HEIGHT);
  localparam logic [10:0] HS_LO  = 11'(WIDTH + H_FP);
  localparam logic [10:0] HS_HI  = 11'(WIDTH + H_FP + H_SYNC);
  localparam logic [9:0]  VS_LO  = 10'(HEIGHT + V_FP);
  localparam logic [9:0]  VS_HI  = 10'(HEIGHT + V_FP + V_SYNC);

  // Per-pixel state carried alongside the request while the source fetches it.
  // Only y[5] is needed downstream, for the checkerboard.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic        fs;
    logic [1:0]  mode;
    logic [10:0] x;
    logic        y5;
  } stage_t;

  localparam stage_t IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, fs: 1'b0,
                              mode: 2'd0, x: 11'd0, y5: 1'b0};

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [1:0]  mode_q;
  logic [1:0]  cur_mode;
  logic        frame_top;
  logic        active;
  stage_t      cur;
  stage_t      stg [PIX_LAT];
  stage_t      tail;
  logic [2:0]  bar_idx;
  logic [23:0] pat;

  // Raster counters: h wraps at line end, v advances on every h wrap.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Region decode of the current counters. The frame's mode is taken straight
  // from the input at (0,0), so the first request of a frame already uses it.
  always_comb begin
    frame_top   = (h_cnt == 11'd0) && (v_cnt == 10'd0);
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    cur_mode    = frame_top ? mode : mode_q;
    cur.hs      = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
    cur.vs      = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));
    cur.blank_n = active;
    cur.fs      = frame_top;
    cur.mode    = cur_mode;
    cur.x       = h_cnt;
    cur.y5      = v_cnt[5];
  end

  assign pix_req     = active && !reset;
  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign oVGA_SYNC_N = 1'b0;

  // Frame mode register; it follows the input directly while in reset.
  always_ff @(posedge VGA_CLK) begin
    if (reset) mode_q <= mode;
    else       mode_q <= cur_mode;
  end

  // Delay line matching the source latency; reset flushes it to idle so no
  // stale pixel can emerge after a restart.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      for (int i = 0; i < PIX_LAT; i++) stg[i] <= IDLE;
    end else begin
      stg[0] <= cur;
      for (int i = 1; i < PIX_LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign tail = stg[PIX_LAT-1];

  // Colour selection for the pixel whose external data is on pix_rgb now.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (tail.x >= 11'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
    pat = 24'h000000;
    case (tail.mode)
      2'd0:    pat = pix_rgb;
      2'd1:    pat = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      2'd2:    pat = (tail.x[5] ^ tail.y5) ? 24'hFFFFFF : 24'h000000;
      default: pat = {3{tail.x[9:2]}};
    endcase
    if (!tail.blank_n) pat = 24'h000000;
  end

  // Registered output stage: the last delay slot plus the selected colour.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      oVGA_R       <= 8'd0;
      oVGA_G       <= 8'd0;
      oVGA_B       <= 8'd0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      oVGA_R       <= pat[23:16];
      oVGA_G       <= pat[15:8];
      oVGA_B       <= pat[7:0];
      oVGA_HS      <= tail.hs;
      oVGA_VS      <= tail.vs;
      oVGA_BLANK_N <= tail.blank_n;
      frame_start  <= tail.fs;
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Bench for vga_stream_gen with a reduced raster so several frames fit in a
// short run. The model derives every expected output from the cycle count since
// reset release, using plain raster arithmetic.
module tb_vga_stream_gen;

  localparam int W = 64, H = 40;
  localparam int HFP = 4, HSY = 6, HBP = 6;
  localparam int VFP = 2, VSY = 2, VBP = 3;
  localparam int LAT = 2;
  localparam int HT = W + HFP + HSY + HBP;   // 80
  localparam int VT = H + VFP + VSY + VBP;   // 47
  localparam int FRAME = HT * VT;            // 3760
  localparam int D = LAT + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd3;
  logic [23:0] pix_rgb = 24'd0;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, frame_start;

  // clock
  always #5 clk = ~clk;

  vga_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIX_LAT(LAT)
  ) dut (
    .VGA_CLK(clk), .reset(reset), .mode(mode), .pix_rgb(pix_rgb),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_SYNC_N(oVGA_SYNC_N),
    .oVGA_BLANK_N(oVGA_BLANK_N), .frame_start(frame_start)
  );

  int n_vec = 0;
  int n_bad = 0;
  int t = -1;
  int cyc = 0;
  int fmode [16];

  // external source request history, newest first
  logic        src_v [LAT];
  logic [10:0] src_x [LAT];
  logic [9:0]  src_y [LAT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int m, input int x, input int y);
    logic [7:0] xs, ys, g;
    xs = 8'(x);
    ys = 8'(y);
    g  = 8'(x / 4);
    case (m)
      0: return {xs, ys, 8'hA5};
      1: case (x / (W / 8))
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return {g, g, g};
    endcase
  endfunction

  task automatic check_out(input logic eb, input logic ehs, input logic evs,
                           input logic efs, input logic [23:0] er);
    chk("blank_n", 32'(oVGA_BLANK_N), 32'(eb));
    chk("hs", 32'(oVGA_HS), 32'(ehs));
    chk("vs", 32'(oVGA_VS), 32'(evs));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(er));
    chk("sync_n", 32'(oVGA_SYNC_N), 32'd0);
  endtask

  // run-length trackers measured on the DUT outputs
  bit   prev_rst = 1'b0;
  logic prev_blank = 1'b0, prev_hs = 1'b1;
  bit   blank_ok = 0, hs_ok = 0, rise_seen = 0, fs_seen = 0;
  int   blank_run = 0, hs_run = 0, since_rise = 0, last_fs = 0;

  // compare process: model vs DUT on the falling edge of every cycle
  always @(negedge clk) begin
    int q, rh, rv, p, oh, ov, m, f;
    logic eb, ehs, evs, efs;
    logic [23:0] er;
    cyc++;
    for (int i = LAT - 1; i > 0; i--) begin
      src_v[i] = src_v[i-1];
      src_x[i] = src_x[i-1];
      src_y[i] = src_y[i-1];
    end
    src_v[0] = pix_req;
    src_x[0] = pix_x;
    src_y[0] = pix_y;

    if (reset) begin
      chk("req_in_reset", 32'(pix_req), 32'd0);
      if (prev_rst) begin
        check_out(1'b0, 1'b1, 1'b1, 1'b0, 24'd0);
        chk("x_in_reset", 32'(pix_x), 32'd0);
        chk("y_in_reset", 32'(pix_y), 32'd0);
      end
      t = -1;
      blank_ok = 0; hs_ok = 0; rise_seen = 0; fs_seen = 0;
    end else begin
      t++;
      q  = t % FRAME;
      rh = q % HT;
      rv = q / HT;
      if (q == 0 && (t / FRAME) < 16) fmode[t / FRAME] = int'(mode);
      chk("pix_req", 32'(pix_req), 32'((rh < W) && (rv < H)));
      chk("pix_x", 32'(pix_x), 32'(rh));
      chk("pix_y", 32'(pix_y), 32'(rv));
      if (t == 0) chk("start_req", 32'(pix_req), 32'd1);

      if (t < D) begin
        check_out(1'b0, 1'b1, 1'b1, 1'b0, 24'd0);
      end else begin
        p  = (t - D) % FRAME;
        oh = p % HT;
        ov = p / HT;
        f  = (t - D) / FRAME;
        m  = (f < 16) ? fmode[f] : 0;
        eb  = (oh < W) && (ov < H);
        ehs = !((oh >= W + HFP) && (oh < W + HFP + HSY));
        evs = !((ov >= H + VFP) && (ov < H + VFP + VSY));
        efs = (p == 0);
        er  = eb ? model_rgb(m, oh, ov) : 24'd0;
        check_out(eb, ehs, evs, efs, er);
        if (t == D) begin
          chk("first_blank_n", 32'(oVGA_BLANK_N), 32'd1);
          chk("first_fs", 32'(frame_start), 32'd1);
        end
        if (m == 3 && oh == W - 1 && ov < H)
          chk("gray_last", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h0F0F0F);
        if (m == 1 && oh == 10 && ov < H)
          chk("bar_yellow", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'hFFFF00);
        if (m == 2 && oh == 32 && ov == 0)
          chk("chk_white", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'hFFFFFF);
        if (m == 2 && oh == 32 && ov == 32)
          chk("chk_black", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'h000000);
      end

      if (rise_seen) since_rise++;
      if (oVGA_BLANK_N && !prev_blank) begin
        blank_ok = 1; blank_run = 0; rise_seen = 1; since_rise = 0;
      end
      if (oVGA_BLANK_N) blank_run++;
      else if (prev_blank && blank_ok) chk("blank_len", 32'(blank_run), 32'(W));
      if (!oVGA_HS && prev_hs) begin
        hs_ok = 1; hs_run = 0;
        if (rise_seen && since_rise < HT) chk("hs_offset", 32'(since_rise), 32'(W + HFP));
      end
      if (!oVGA_HS) hs_run++;
      else if (!prev_hs && hs_ok) chk("hs_len", 32'(hs_run), 32'(HSY));
      if (frame_start) begin
        if (fs_seen) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
        fs_seen = 1;
        last_fs = cyc;
      end
    end
    prev_rst   = reset;
    prev_blank = oVGA_BLANK_N;
    prev_hs    = oVGA_HS;
  end

  // driver: advance one cycle, then play the source's returned pixel
  task automatic step();
    @(posedge clk);
    #1;
    if (src_v[LAT-1]) pix_rgb = {src_x[LAT-1][7:0], src_y[LAT-1][7:0], 8'hA5};
    else              pix_rgb = 24'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      src_v[i] = 1'b0; src_x[i] = '0; src_y[i] = '0;
    end
    for (int i = 0; i < 16; i++) fmode[i] = 0;

    // startup: 5 reset cycles in gray-ramp mode
    reset = 1'b1;
    mode  = 2'd3;
    repeat (5) step();
    reset = 1'b0;

    // frames 0,1 gray; frame 2 external; frame 3 bars; frame 4 checker
    run(FRAME + 100);
    mode = 2'd0;
    run(FRAME);
    mode = 2'd1;
    run(FRAME - 100 + 10 * HT);
    mode = 2'd2;
    run(FRAME + 10 * HT + 30);

    // one-cycle reset mid-line
    reset = 1'b1;
    step();
    reset = 1'b0;

    // random mode changes
    for (int i = 0; i < 10; i++) begin
      run($urandom_range(100, 900));
      mode = 2'($urandom_range(0, 3));
    end

    // random-length reset at a random point, then two checker frames
    run($urandom_range(0, HT - 1));
    reset = 1'b1;
    repeat ($urandom_range(1, 4)) step();
    mode  = 2'd2;
    reset = 1'b0;
    run(2 * FRAME + 50);
    mode = 2'($urandom_range(0, 3));
    run(FRAME + D + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
